// File: rtl/mem_port_if.sv
// Request/response bundle between the CPU fetch and load/store paths, the
// port arbiter and the single-ported SRAM macro.
interface mem_port_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic              if_valid;
    logic [DW-1:0]     if_rdata;

    logic              d_read;
    logic [DW/8-1:0]   d_write;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic              d_valid;
    logic [DW-1:0]     d_rdata;

    logic              mem_cs;
    logic [DW/8-1:0]   mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
        output if_valid, if_rdata, d_valid, d_rdata,
        output mem_cs, mem_we, mem_addr, mem_wdata
    );

    // CPU core plus SRAM side
    modport master (
        output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata,
        input  mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store accesses onto one single-ported SRAM, one access in flight.
// Define MEM_ARB_PERF_EN to build the cnt_fetch/cnt_stall performance counters.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_if.slave        bus,
    output logic             err_both,
    output logic [CNT_W-1:0] cnt_fetch,
    output logic [CNT_W-1:0] cnt_stall
);
    localparam int LW = 3;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ACK} state_t;
    typedef enum logic {GNT_FETCH, GNT_DATA} gnt_t;

    state_t        state, state_nxt;
    gnt_t          last_gnt, owner, gnt;
    logic [LW-1:0] lat_cnt;
    logic          d_store, if_pend, d_pend, issue, last_count;

    // A requester still holds its req in the cycle its valid pulses; mask it so it is not re-issued.
    assign d_store    = |bus.d_write;
    assign if_pend    = bus.if_req & ~bus.if_valid;
    assign d_pend     = (bus.d_read | d_store) & ~bus.d_valid;
    assign last_count = (lat_cnt == LW'(MEM_LAT));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_nxt = state;
        gnt       = last_gnt;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (if_pend || d_pend) begin
                    issue = 1'b1;
                    if (if_pend && d_pend)
                        gnt = (last_gnt == GNT_DATA) ? GNT_FETCH : GNT_DATA;
                    else
                        gnt = if_pend ? GNT_FETCH : GNT_DATA;
                    state_nxt = (gnt == GNT_DATA && d_store) ? WR_ACK : RD_WAIT;
                end
            end
            RD_WAIT: if (last_count) state_nxt = IDLE;
            WR_ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt      <= GNT_DATA;
            owner         <= GNT_DATA;
            lat_cnt       <= '0;
            bus.mem_cs    <= 1'b0;
            bus.mem_we    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_valid  <= 1'b0;
            bus.d_valid   <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
            err_both      <= 1'b0;
        end else begin
            bus.mem_cs   <= issue;
            bus.mem_we   <= '0;
            bus.if_valid <= 1'b0;
            bus.d_valid  <= 1'b0;
            lat_cnt      <= (state == RD_WAIT) ? lat_cnt + 1'b1 : '0;

            if (issue) begin
                last_gnt <= gnt;
                owner    <= gnt;
                if (gnt == GNT_FETCH) begin
                    bus.mem_addr <= {bus.if_addr[AW-1:2], 2'b00};
                end else begin
                    bus.mem_addr  <= {bus.d_addr[AW-1:2], 2'b00};
                    bus.mem_we    <= bus.d_write;
                    bus.mem_wdata <= bus.d_wdata;
                end
            end

            if (state == RD_WAIT && last_count) begin
                if (owner == GNT_FETCH) begin
                    bus.if_rdata <= bus.mem_rdata;
                    bus.if_valid <= 1'b1;
                end else begin
                    bus.d_rdata <= bus.mem_rdata;
                    bus.d_valid <= 1'b1;
                end
            end

            if (state == WR_ACK) bus.d_valid <= 1'b1;

            if (bus.d_read && d_store) err_both <= 1'b1;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic if_stall, d_stall;

    // Waiting means pending but neither granted this cycle nor owning the access in flight.
    assign if_stall = if_pend && !(issue && gnt == GNT_FETCH)
                      && !(state != IDLE && owner == GNT_FETCH);
    assign d_stall  = d_pend && !(issue && gnt == GNT_DATA)
                      && !(state != IDLE && owner == GNT_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_fetch <= '0;
            cnt_stall <= '0;
        end else begin
            if (state == RD_WAIT && last_count && owner == GNT_FETCH)
                cnt_fetch <= cnt_fetch + 1'b1;
            cnt_stall <= cnt_stall + CNT_W'(if_stall) + CNT_W'(d_stall);
        end
    end
`else
    assign cnt_fetch = '0;
    assign cnt_stall = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LAT=1 instance plus a MEM_LAT=3 instance for the
// long-latency load; includes an SRAM model that returns data only on the exact latency cycle.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_if #(.AW(32), .DW(32)) b0 ();
    mem_port_if #(.AW(32), .DW(32)) b3 ();

    logic        err0, err3;
    logic [31:0] cf0, cs0_cnt, cf3, cs3_cnt;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(b0.slave),
        .err_both(err0), .cnt_fetch(cf0), .cnt_stall(cs0_cnt)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .CNT_W(32)) dut3 (
        .clk(clk), .rst(rst), .bus(b3.slave),
        .err_both(err3), .cnt_fetch(cf3), .cnt_stall(cs3_cnt)
    );

    // SRAM model shared by both instances
    logic [31:0] mem [0:63];
    logic [2:0]  lc0, lc3;
    logic [31:0] ra0, ra3;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            lc0 <= '0;
            lc3 <= '0;
        end else begin
            if (b0.mem_cs) begin
                if (b0.mem_we != 4'b0) begin
                    mem[b0.mem_addr[7:2]] <= merge(mem[b0.mem_addr[7:2]], b0.mem_wdata, b0.mem_we);
                    lc0 <= '0;
                end else begin
                    lc0 <= 3'd1;
                    ra0 <= b0.mem_addr;
                end
            end else if (lc0 != 3'd0 && lc0 != 3'd7) lc0 <= lc0 + 3'd1;
            if (b3.mem_cs && b3.mem_we == 4'b0) begin
                lc3 <= 3'd1;
                ra3 <= b3.mem_addr;
            end else if (lc3 != 3'd0 && lc3 != 3'd7) lc3 <= lc3 + 3'd1;
        end
    end

    assign b0.mem_rdata = (lc0 == 3'd1) ? mem[ra0[7:2]] : 32'hBAD0_BAD0;
    assign b3.mem_rdata = (lc3 == 3'd3) ? mem[ra3[7:2]] : 32'hBAD0_BAD0;

    // Bus monitor for the MEM_LAT=1 instance
    int          cs_seen, ifv_seen;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_we;
    initial begin
        cs_seen  = 0;
        ifv_seen = 0;
    end
    always @(negedge clk) begin
        if (b0.mem_cs) begin
            cs_seen++;
            last_addr  <= b0.mem_addr;
            last_we    <= b0.mem_we;
            last_wdata <= b0.mem_wdata;
        end
        if (b0.if_valid) ifv_seen++;
    end

    int          n_vec, n_err;
    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_if(input int exp_lat);
        int n = 0;
        do begin tick(); n++; end while (!b0.if_valid && n < 20);
        check("if_lat", n, exp_lat);
        check("if_rdata", b0.if_rdata, exp_if.pop_front());
        b0.if_req = 1'b0;
    endtask

    task automatic wait_d(input int exp_lat);
        int n = 0;
        do begin tick(); n++; end while (!b0.d_valid && n < 20);
        check("d_lat", n, exp_lat);
        check("d_rdata", b0.d_rdata, exp_d.pop_front());
        b0.d_read  = 1'b0;
        b0.d_write = '0;
    endtask

    task automatic start_fetch(input logic [31:0] a, input logic [31:0] e);
        b0.if_req  = 1'b1;
        b0.if_addr = a;
        exp_if.push_back(e);
    endtask

    task automatic start_load(input logic [31:0] a, input logic [31:0] e);
        b0.d_read = 1'b1;
        b0.d_addr = a;
        exp_d.push_back(e);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int base_cs, base_ifv, n;
        logic [31:0] base_stall;
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0100_0000 + i;
        mem[4]  = 32'h0050_0093;   // 0x10
        mem[8]  = 32'h1122_3344;   // 0x20
        mem[16] = 32'hDEAD_BEEF;   // 0x40
        b0.if_req = 0; b0.if_addr = '0; b0.d_read = 0; b0.d_write = '0;
        b0.d_addr = '0; b0.d_wdata = '0;
        b3.if_req = 0; b3.if_addr = '0; b3.d_read = 0; b3.d_write = '0;
        b3.d_addr = '0; b3.d_wdata = '0;
        #1;
        apply_reset();

        check("rst_mem_cs", b0.mem_cs, 0);
        check("rst_mem_we", b0.mem_we, 0);
        check("rst_if_valid", b0.if_valid, 0);
        check("rst_d_valid", b0.d_valid, 0);
        check("rst_err_both", err0, 0);
        check("rst_cnt_fetch", cf0, 0);
        check("rst_cnt_stall", cs0_cnt, 0);
        check("rst_rdata", {b0.if_rdata, b0.d_rdata}, 0);

        // Same-cycle fetch and load after reset: fetch goes first
        start_fetch(32'h10, 32'h0050_0093);
        start_load(32'h40, 32'hDEAD_BEEF);
        fork
            wait_if(3);
            wait_d(6);
        join
        check("both_stall", cs0_cnt, PERF ? 3 : 0);
        check("both_fetch_cnt", cf0, PERF ? 1 : 0);

        // Fetch alone
        base_cs = cs_seen;
        start_fetch(32'h10, 32'h0050_0093);
        wait_if(3);
        check("fetch_cs_once", cs_seen - base_cs, 1);
        check("fetch_mem_addr", last_addr, 32'h10);

        // Both again after a fetch grant: load wins this time
        base_stall = cs0_cnt;
        start_fetch(32'h20, 32'h1122_3344);
        start_load(32'h10, 32'h0050_0093);
        fork
            wait_if(6);
            wait_d(3);
        join
        check("alt_stall", cs0_cnt - base_stall, PERF ? 3 : 0);
        check("alt_fetch_cnt", cf0, PERF ? 3 : 0);

        // Byte store; d_rdata holds the last loaded word
        base_cs = cs_seen;
        b0.d_write = 4'b0100;
        b0.d_addr  = 32'h21;
        b0.d_wdata = 32'h00AB_0000;
        exp_d.push_back(32'h0050_0093);
        wait_d(2);
        check("sb_cs_once", cs_seen - base_cs, 1);
        check("sb_mem_we", last_we, 4'b0100);
        check("sb_mem_addr", last_addr, 32'h20);
        check("sb_mem_wdata", last_wdata, 32'h00AB_0000);
        start_fetch(32'h20, 32'h11AB_3344);
        wait_if(3);

        // MEM_LAT=3 load
        b3.d_read = 1'b1;
        b3.d_addr = 32'h40;
        exp_d.push_back(32'hDEAD_BEEF);
        n = 0;
        do begin tick(); n++; end while (!b3.d_valid && n < 20);
        check("lat3_d_lat", n, 5);
        check("lat3_d_rdata", b3.d_rdata, exp_d.pop_front());
        b3.d_read = 1'b0;

        // Reset while the fetch sits in RD_WAIT
        base_cs  = cs_seen;
        base_ifv = ifv_seen;
        b0.if_req  = 1'b1;
        b0.if_addr = 32'h10;
        tick();
        b0.if_req = 1'b0;
        apply_reset();
        repeat (5) tick();
        check("rstmid_no_valid", ifv_seen - base_ifv, 0);
        check("rstmid_cs_once", cs_seen - base_cs, 1);
        check("rstmid_mem_cs", b0.mem_cs, 0);
        check("rstmid_counters", {cf0, cs0_cnt}, 0);
        check("rstmid_if_rdata", b0.if_rdata, 0);
        start_fetch(32'h10, 32'h0050_0093);
        wait_if(3);

        // Load and store together: store wins, error is sticky
        b0.d_read  = 1'b1;
        b0.d_write = 4'b1111;
        b0.d_addr  = 32'h30;
        b0.d_wdata = 32'h1234_5678;
        exp_d.push_back(32'h0);
        wait_d(2);
        check("both_rw_we", last_we, 4'b1111);
        check("both_rw_err", err0, 1);
        start_fetch(32'h30, 32'h1234_5678);
        wait_if(3);
        check("both_rw_err_sticky", err0, 1);
        apply_reset();
        check("both_rw_err_clr", err0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
